// File: rtl/data_memory_sized_if.sv
// Purpose: load/store request and response bundle for the MIPS data memory.
// Latency: none, plain wires.
// Backpressure: Ready from the memory gates all requests; responses cannot be stalled.
interface data_memory_sized_if;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  MemSize;
  logic        MemUnsigned;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        Ready;
  logic [31:0] ReadData;
  logic        ReadValid;
  logic        Fault;
  logic [1:0]  FaultCause;
  logic [31:0] FaultAddr;

  // Datapath side: issues requests, consumes responses.
  modport master (
    output MemRead, MemWrite, MemSize, MemUnsigned, Address, WriteData,
    input  Ready, ReadData, ReadValid, Fault, FaultCause, FaultAddr
  );

  // Memory side.
  modport slave (
    input  MemRead, MemWrite, MemSize, MemUnsigned, Address, WriteData,
    output Ready, ReadData, ReadValid, Fault, FaultCause, FaultAddr
  );
endinterface

// File: rtl/data_memory_sized.sv
// Purpose: byte-addressed little-endian data memory with sized/extended loads, fault flags and clear-on-reset.
// Latency: load data and fault pulse READ_LATENCY cycles after the accepting edge; stores write at that edge.
// Backpressure: Ready low during the post-reset clear; requests then are dropped, otherwise one request per cycle.
module data_memory_sized #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          MEMORY_DEPTH   = 256,
  parameter logic [31:0] BASE_ADDR      = 32'h10010000,
  parameter int          READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  data_memory_sized_if.slave   bus
);

  localparam int          IDXW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [31:0] SPAN = 32'(MEMORY_DEPTH * 4);

  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // One response slot travelling down the read pipeline.
  typedef struct packed {
    logic        rv;
    logic        flt;
    logic [1:0]  cause;
    logic [31:0] addr;
    logic [31:0] data;
  } respT;

  logic [0:0]            state;
  logic [IDXW-1:0]       clearIdx;
  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  logic [31:0]     offset;
  logic [IDXW-1:0] wordIdx;
  logic [1:0]      lane;
  logic            ready;
  logic            accept;
  logic            isLoad;
  logic            doWrite;
  logic            misaligned;
  logic            outOfRange;
  logic [1:0]      reqCause;
  logic [3:0]      byteEn;
  logic [31:0]     laneData;

  // Stage 1: raw word plus what is needed to pick and extend the lanes.
  logic                  s0Rv;
  logic                  s0Flt;
  logic [1:0]            s0Cause;
  logic [31:0]           s0Addr;
  logic [DATA_WIDTH-1:0] s0Word;
  logic [1:0]            s0Lane;
  logic [1:0]            s0Size;
  logic                  s0Uns;

  logic [7:0]  byteV;
  logic [15:0] halfV;
  logic [31:0] extData;
  respT        resp0;
  respT        respOut;

  logic [1:0]  heldCause;
  logic [31:0] heldAddr;

  assign ready   = (state == RUN);
  // Below-base addresses wrap to huge offsets and so land in the range check.
  assign offset  = bus.Address - BASE_ADDR;
  assign wordIdx = offset[IDXW+1:2];
  assign lane    = offset[1:0];

  // Request decode: fault classification, byte enables and lane-replicated store data.
  always_comb begin
    misaligned = 1'b0;
    byteEn     = 4'b1111;
    laneData   = bus.WriteData;
    case (bus.MemSize)
      2'b00: begin
        misaligned = 1'b0;
        byteEn     = 4'b0001 << lane;
        laneData   = {4{bus.WriteData[7:0]}};
      end
      2'b01: begin
        misaligned = lane[0];
        byteEn     = lane[1] ? 4'b1100 : 4'b0011;
        laneData   = {2{bus.WriteData[15:0]}};
      end
      default: begin
        misaligned = (lane != 2'b00);
        byteEn     = 4'b1111;
        laneData   = bus.WriteData;
      end
    endcase
    outOfRange = (offset >= SPAN);
    if (bus.MemRead && bus.MemWrite) begin
      reqCause = 2'b11;
    end else if (misaligned) begin
      reqCause = 2'b01;
    end else if (outOfRange) begin
      reqCause = 2'b10;
    end else begin
      reqCause = 2'b00;
    end
    accept  = (bus.MemRead | bus.MemWrite) & ready;
    isLoad  = bus.MemRead & ~bus.MemWrite;
    doWrite = accept & bus.MemWrite & ~bus.MemRead & (reqCause == 2'b00);
  end

  // Clear/run sequencer: walk every word once after reset, then serve requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      clearIdx <= '0;
    end else if (state == INIT) begin
      if (!CLEAR_ON_RESET || clearIdx == IDXW'(MEMORY_DEPTH - 1)) begin
        state <= RUN;
      end else begin
        clearIdx <= clearIdx + 1'b1;
      end
    end
  end

  // Array writes: clearing sweep during INIT, masked lane stores during RUN.
  always_ff @(posedge clk) begin
    if (CLEAR_ON_RESET && !reset && state == INIT) begin
      mem[clearIdx] <= '0;
    end else if (doWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) begin
          mem[wordIdx][8*i +: 8] <= laneData[8*i +: 8];
        end
      end
    end
  end

  // Stage 1 capture: array read at the accepting edge, so earlier stores are always visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      s0Rv    <= 1'b0;
      s0Flt   <= 1'b0;
      s0Cause <= 2'b00;
      s0Addr  <= '0;
      s0Word  <= '0;
      s0Lane  <= 2'b00;
      s0Size  <= 2'b00;
      s0Uns   <= 1'b0;
    end else begin
      s0Rv    <= accept & isLoad;
      s0Flt   <= accept & (reqCause != 2'b00);
      s0Cause <= reqCause;
      s0Addr  <= bus.Address;
      s0Word  <= mem[wordIdx];
      s0Lane  <= lane;
      s0Size  <= bus.MemSize;
      s0Uns   <= bus.MemUnsigned;
    end
  end

  // Lane select and sign/zero extension; faulting loads return zero.
  always_comb begin
    byteV = s0Word[{s0Lane, 3'b000} +: 8];
    halfV = s0Lane[1] ? s0Word[31:16] : s0Word[15:0];
    case (s0Size)
      2'b00:   extData = s0Uns ? {24'h0, byteV} : {{24{byteV[7]}}, byteV};
      2'b01:   extData = s0Uns ? {16'h0, halfV} : {{16{halfV[15]}}, halfV};
      default: extData = s0Word;
    endcase
    resp0.rv    = s0Rv;
    resp0.flt   = s0Flt;
    resp0.cause = s0Cause;
    resp0.addr  = s0Addr;
    resp0.data  = (s0Rv && !s0Flt) ? extData : 32'h0;
  end

  generate
    if (READ_LATENCY <= 1) begin : gDirect
      assign respOut = resp0;
    end else begin : gDelay
      respT pipe [READ_LATENCY-1];

      // Pure delay line after extension; no stalls, so responses stay in order.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < READ_LATENCY - 1; i++) begin
            pipe[i] <= '0;
          end
        end else begin
          pipe[0] <= resp0;
          for (int i = 1; i < READ_LATENCY - 1; i++) begin
            pipe[i] <= pipe[i-1];
          end
        end
      end

      assign respOut = pipe[READ_LATENCY-2];
    end
  endgenerate

  // Remember the last fault so cause/address stay visible after the pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      heldCause <= 2'b00;
      heldAddr  <= '0;
    end else if (respOut.flt) begin
      heldCause <= respOut.cause;
      heldAddr  <= respOut.addr;
    end
  end

  assign bus.Ready      = ready;
  assign bus.ReadValid  = respOut.rv;
  assign bus.ReadData   = respOut.rv ? respOut.data : 32'h0;
  assign bus.Fault      = respOut.flt;
  assign bus.FaultCause = respOut.flt ? respOut.cause : heldCause;
  assign bus.FaultAddr  = respOut.flt ? respOut.addr : heldAddr;

endmodule
